conv_pool_engine: RTL

- Parametrised successor to the fixed 64x64 single-kernel convolution block.
- Runs 3x3 zero-padded convolution, bias, ReLU and saturation for NUM_KER runtime-loadable kernels; writes each layer-0 map, then optionally a 2x2 stride-2 max-pool layer-1 map.
- Sits between the image ROM (iaddr/idata) and the shared layer RAM bank (csel/caddr/cdata) under testbench or host control.

---
 rtl/conv_pool_engine.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_pool_engine.sv
// 3x3 zero-padded convolution, bias, ReLU and saturation over NUM_KER loadable kernels,
// each followed by an optional 2x2 stride-2 max-pool pass into the next layer bank.
module conv_pool_engine #(
  parameter int unsigned W_LOG2  = 6,
  parameter int unsigned H_LOG2  = 6,
  parameter int unsigned DW      = 20,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned NUM_KER = 1,
  parameter int unsigned POOL_EN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ready,
  output logic                     busy,
  input  logic                     kw_we,
  input  logic [1:0]               kw_sel,
  input  logic [3:0]               kw_idx,
  input  logic [DW-1:0]            kw_data,
  output logic [W_LOG2+H_LOG2-1:0] iaddr,
  input  logic [DW-1:0]            idata,
  output logic                     cwr,
  output logic [W_LOG2+H_LOG2-1:0] caddr_wr,
  output logic [DW-1:0]            cdata_wr,
  output logic                     crd,
  output logic [W_LOG2+H_LOG2-1:0] caddr_rd,
  input  logic [DW-1:0]            cdata_rd,
  output logic [2:0]               csel
);

  localparam int unsigned AW   = W_LOG2 + H_LOG2;
  localparam int unsigned PW   = AW - 2;
  localparam int unsigned ACCW = 2 * DW + 4;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StConv   = 3'd1;
  localparam logic [2:0] StWb     = 3'd2;
  localparam logic [2:0] StPoolRd = 3'd3;
  localparam logic [2:0] StPoolWb = 3'd4;

  localparam logic [1:0]      LastKer = 2'(NUM_KER - 1);
  localparam logic [2:0]      L1Base  = 3'(NUM_KER + 1);
  localparam logic [ACCW-1:0] Half    = ACCW'(1) << (FRAC - 1);
  localparam logic [ACCW-1:0] MaxV    = {{(ACCW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};

  logic [2:0]    state_q, state_d;
  logic [3:0]    tap_q, tap_d;
  logic [AW-1:0] pix_q, pix_d;
  logic [1:0]    kern_q, kern_d;
  logic [PW-1:0] pidx_q, pidx_d;
  logic [1:0]    rd_q, rd_d;

  logic signed [DW-1:0]   w_q [4][10];
  logic signed [DW-1:0]   tapv_q;
  logic signed [ACCW-1:0] acc_q;
  logic [DW-1:0]          res_q, res_d;
  logic [DW-1:0]          max_q;

  // Tap geometry: row/col of the 3x3 window, neighbour address and image bounds.
  logic [1:0]        row, col;
  logic [3:0]        col4;
  logic [W_LOG2-1:0] px, nx;
  logic [H_LOG2-1:0] py, ny;
  logic              in_img, fetch;
  logic [DW-1:0]     tap_val;

  always_comb begin
    row    = (tap_q >= 4'd6) ? 2'd2 : ((tap_q >= 4'd3) ? 2'd1 : 2'd0);
    col4   = tap_q - ((row == 2'd2) ? 4'd6 : ((row == 2'd1) ? 4'd3 : 4'd0));
    col    = col4[1:0];
    px     = pix_q[W_LOG2-1:0];
    py     = pix_q[AW-1:W_LOG2];
    nx     = px + W_LOG2'(col) - W_LOG2'(1);
    ny     = py + H_LOG2'(row) - H_LOG2'(1);
    in_img = !(col == 2'd0 && px == '0) && !(col == 2'd2 && (&px)) &&
             !(row == 2'd0 && py == '0) && !(row == 2'd2 && (&py));
    fetch   = (state_q == StConv) && (tap_q <= 4'd8);
    tap_val = in_img ? idata : '0;
  end

  // MAC operands: tap registered in cycle c is multiplied by weight c in cycle c+1.
  logic [3:0]               widx;
  logic signed [2*DW-1:0]   prod;
  logic signed [DW-1:0]     bias;
  logic [ACCW-1:0]          prod_ext, bias_acc;
  logic signed [ACCW-1:0]   rnd, shr;

  always_comb begin
    widx     = (tap_q == 4'd0) ? 4'd0 : tap_q - 4'd1;
    prod     = tapv_q * w_q[kern_q][widx];
    prod_ext = {{4{prod[2*DW-1]}}, prod};
    bias     = w_q[kern_q][9];
    bias_acc = {{(DW + 4 - FRAC){bias[DW-1]}}, bias, {FRAC{1'b0}}};
    rnd      = acc_q + $signed(Half);
    shr      = rnd >>> FRAC;
    if (shr[ACCW-1]) begin
      res_d = '0;
    end else if (shr > $signed(MaxV)) begin
      res_d = MaxV[DW-1:0];
    end else begin
      res_d = shr[DW-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tapv_q <= '0;
      acc_q  <= '0;
      res_q  <= '0;
      max_q  <= '0;
    end else begin
      if (state_q == StConv) begin
        if (tap_q <= 4'd8) tapv_q <= tap_val;
        if (tap_q == 4'd0) begin
          acc_q <= $signed(bias_acc);
        end else if (tap_q <= 4'd9) begin
          acc_q <= acc_q + $signed(prod_ext);
        end
        if (tap_q == 4'd10) res_q <= res_d;
      end
      if (state_q == StPoolRd && (rd_q == 2'd0 || $signed(cdata_rd) > $signed(max_q))) begin
        max_q <= cdata_rd;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 10; i++) begin
          w_q[k][i] <= '0;
        end
      end
    end else if (kw_we && state_q == StIdle && kw_sel <= LastKer && kw_idx <= 4'd9) begin
      w_q[kw_sel][kw_idx] <= kw_data;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    pix_d   = pix_q;
    kern_d  = kern_q;
    pidx_d  = pidx_q;
    rd_d    = rd_q;
    case (state_q)
      StIdle: begin
        tap_d  = '0;
        pix_d  = '0;
        kern_d = '0;
        if (ready) state_d = StConv;
      end
      StConv: begin
        if (tap_q == 4'd10) begin
          tap_d   = '0;
          state_d = StWb;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      StWb: begin
        if (!(&pix_q)) begin
          pix_d   = pix_q + 1'b1;
          state_d = StConv;
        end else begin
          pix_d = '0;
          if (POOL_EN != 0) begin
            pidx_d  = '0;
            rd_d    = '0;
            state_d = StPoolRd;
          end else if (kern_q == LastKer) begin
            state_d = StIdle;
          end else begin
            kern_d  = kern_q + 2'd1;
            state_d = StConv;
          end
        end
      end
      StPoolRd: begin
        rd_d = rd_q + 2'd1;
        if (rd_q == 2'd3) state_d = StPoolWb;
      end
      StPoolWb: begin
        if (!(&pidx_q)) begin
          pidx_d  = pidx_q + 1'b1;
          state_d = StPoolRd;
        end else begin
          pidx_d = '0;
          if (kern_q == LastKer) begin
            state_d = StIdle;
          end else begin
            kern_d  = kern_q + 2'd1;
            state_d = StConv;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      tap_q   <= '0;
      pix_q   <= '0;
      kern_q  <= '0;
      pidx_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      pix_q   <= pix_d;
      kern_q  <= kern_d;
      pidx_q  <= pidx_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset silences them at once.
  always_comb begin
    busy     = (state_q != StIdle);
    cwr      = (state_q == StWb) || (state_q == StPoolWb);
    crd      = (state_q == StPoolRd);
    iaddr    = fetch ? (in_img ? {ny, nx} : pix_q) : '0;
    caddr_wr = '0;
    cdata_wr = '0;
    caddr_rd = '0;
    csel     = '0;
    case (state_q)
      StWb: begin
        caddr_wr = pix_q;
        cdata_wr = res_q;
        csel     = 3'd1 + {1'b0, kern_q};
      end
      StPoolRd: begin
        caddr_rd = {pidx_q[PW-1:W_LOG2-1], rd_q[1], pidx_q[W_LOG2-2:0], rd_q[0]};
        csel     = 3'd1 + {1'b0, kern_q};
      end
      StPoolWb: begin
        caddr_wr = AW'(pidx_q);
        cdata_wr = max_q;
        csel     = L1Base + {1'b0, kern_q};
      end
      default: ;
    endcase
  end

endmodule
